logic_unit: RTL and testbench
=============================

# logic_unit

Parametrised, pipelined bitwise logic unit for the ALU datapath, generalising the fixed 4-bit gated AND block. It accepts operands through a valid/ready handshake and executes one of eight bitwise operations under an enable gate. An optional accumulate mode chains results. It returns a registered result with status flags through a 2-entry skid buffer, so the ALU output mux can stall it without dropping data.

## Interface
- WIDTH, 4: operand/result width in bits, ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation code (see Operation).
- enable  in  1  operand gate; 0 forces result to zero.
- acc  in  1  1: use accumulator instead of `a` as operand A.
- acc_clr  in  1  clear accumulator (sampled only on an accepted beat).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- flag_zero  out  1  result == 0.
- flag_ones  out  1  result == all ones.
- flag_parity  out  1  XOR-reduction of result.

## Operation
- Accept occurs when in_valid && in_ready. The same rule applies to the output: out_valid && out_ready.
- Operand A selection is acc_clr ? 0 : (acc ? acc_q : a). The clear takes priority for the operand in the same beat.
- If enable=0, both operands are treated as 0 before the op. The result of op on (0,0) is produced, e.g. NAND gives all ones. This matches the gate-the-inputs behaviour of the original block.
- Op codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT A (B ignored), 7 PASS B (A ignored).
- acc_q (WIDTH bits, reset 0) is loaded with the computed result on every accepted beat, regardless of `acc`. No update occurs without an accept. If acc_clr is set, acc_q still loads that beat's result.
- Flags are computed from the result and travel with it in the buffer.
- Buffer states:
  - EMPTY: no entries.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- Buffer transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no pop → FULL; the new beat goes to skid.
  - ONE + pop, no accept → EMPTY.
  - ONE + accept and pop → ONE; main is replaced.
  - FULL + pop → ONE; skid moves to main. No accept is possible in FULL.
- in_ready = (state != FULL). It is a registered-state decode, not combinational from out_ready.
- out_valid = (state != EMPTY). result and flags come from the main entry, in order.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on result with out_valid high after edge N.
- Throughput is 1 beat/cycle while out_ready stays high.
- out_valid deasserts at most 1 cycle after the last pop.
- Reset values:
  - state EMPTY; out_valid 0; in_ready 1.
  - result 0; flag_zero 0; flag_ones 0; flag_parity 0; acc_qa 0.
- Reset mid-operation discards all buffered results and the accumulator immediately (asynchronous).
- While out_valid && !out_ready, result and flags are held stable.
- The back-to-back accumulate dependency is resolved by acc_q updating at the accept edge. The next beat always sees the previous accepted result, with no bubble.

## Structure
- Package logic_unit_pkg holds:
  - op_e enum (3-bit) with the eight codes above.
  - localparam OP_W = 3.
  - Skid-state enum: EMPTY, ONE, FULL.
- Sub-module logic_unit_skid (parametrised by payload width WIDTH+3) implements the 2-entry skid buffer and its handshake.
- The top level holds:
  - operand muxing, enable gate and op decode;
  - flag generation;
  - the accumulator register.

## Test plan
- WIDTH=4, out_ready=1, enable=1, op=AND, a=4'b1100, b=4'b1010 → result 4'b1000 one cycle later; flag_zero=0, flag_ones=0, flag_parity=1.
- enable=0, op=NAND, a=4'hF, b=4'hF → result 4'hF, flag_ones=1. Repeat with op=AND → result 0, flag_zero=1.
- Accumulate chain, out_ready=1:
  - beat1 acc_clr=1, op=OR, b=4'h3 → 4'h3.
  - beat2 acc=1, op=XOR, b=4'h5 → 4'h6.
  - beat3 acc=1, op=AND, b=4'h4 → 4'h4.
  - No bubble between beats.
- Backpressure: hold out_ready=0, stream three beats → two accepted, in_ready=0 after the second. Release out_ready → results emerge in order, third beat accepted, nothing lost or duplicated.
- Sweep all 8 ops, WIDTH=8, random a/b (1000 beats) → matches reference model; parity and flags correct.
- Assert rst_n low while in FULL → out_valid=0, in_ready=1 and acc_q=0 immediately. The first post-reset beat with acc=1, op=OR, b=8'h01 → 8'h01.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared op codes, widths and skid-buffer state encoding
package logic_unit_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASSB = 3'd7
    } op_e;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_e;
endpackage

// File: rtl/logic_unit_if.sv
// logic_unit_if: operand/result handshake bundle of the logic unit
interface logic_unit_if #(parameter int WIDTH = 4);
    import logic_unit_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0] op;
    logic enable;
    logic acc;
    logic acc_clr;
    logic out_valid;
    logic out_ready;
    logic [WIDTH-1:0] result;
    logic flag_zero;
    logic flag_ones;
    logic flag_parity;
    modport master (
        output in_valid, a, b, op, enable, acc, acc_clr, out_ready,
        input in_ready, out_valid, result, flag_zero, flag_ones, flag_parity
    );
    modport slave (
        input in_valid, a, b, op, enable, acc, acc_clr, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_ones, flag_parity
    );
endinterface

// File: rtl/logic_unit_skid.sv
// logic_unit_skid: 2-entry skid buffer; in_ready decodes registered state only
module logic_unit_skid
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic out_valid,
    input  logic out_ready,
    output logic [WIDTH-1:0] out_data
);
    skid_e state, state_n;
    logic [WIDTH-1:0] main_q, skid_q;
    logic push, pop;
    assign in_ready = state != FULL;
    assign out_valid = state != EMPTY;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign out_data = main_q;
    always_comb begin
        state_n = state;
        case (state)
            EMPTY: state_n = push ? ONE : EMPTY;
            ONE: state_n = (push && !pop) ? FULL : ((pop && !push) ? EMPTY : ONE);
            FULL: state_n = pop ? ONE : FULL;
            default: state_n = EMPTY;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (push && (state == EMPTY || pop)) main_q <= in_data;
            else if (state == FULL && pop) main_q <= skid_q;
            if (push && state == ONE && !pop) skid_q <= in_data;
        end
    end
endmodule

// File: rtl/logic_unit.sv
// logic_unit: gated bitwise op unit with accumulator feeding a skid-buffered result
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic clk,
    input logic rst_n,
    logic_unit_if.slave bus
);
    logic [WIDTH-1:0] acc_q, opa, opb, res, out_res;
    logic [WIDTH+2:0] out_data;
    logic accept;
    op_e op;
    assign op = op_e'(bus.op);
    assign accept = bus.in_valid && bus.in_ready;
    assign opa = (!bus.enable || bus.acc_clr) ? '0 : (bus.acc ? acc_q : bus.a);
    assign opb = bus.enable ? bus.b : '0;
    always_comb begin
        res = '0;
        case (op)
            OP_AND: res = opa & opb;
            OP_OR: res = opa | opb;
            OP_XOR: res = opa ^ opb;
            OP_NAND: res = ~(opa & opb);
            OP_NOR: res = ~(opa | opb);
            OP_XNOR: res = ~(opa ^ opb);
            OP_NOTA: res = ~opa;
            OP_PASSB: res = opb;
            default: res = '0;
        endcase
    end
    // acc_q tracks every accepted result so a following acc beat needs no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else if (accept) acc_q <= res;
    end
    logic_unit_skid #(.WIDTH(WIDTH + 3)) u_skid (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(bus.in_valid),
        .in_ready(bus.in_ready),
        .in_data({res, ~|res, &res, ^res}),
        .out_valid(bus.out_valid),
        .out_ready(bus.out_ready),
        .out_data(out_data)
    );
    assign out_res = out_data[WIDTH+2:3];
    assign bus.result = out_res;
    assign bus.flag_zero = out_data[2];
    assign bus.flag_ones = out_data[1];
    assign bus.flag_parity = out_data[0];
endmodule

// File: tb/tb_logic_unit.sv
// tb_logic_unit: WIDTH=4 and WIDTH=8 units in lockstep against a scoreboard
module tb_logic_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    logic in_valid, enable, acc, acc_clr, out_ready;
    logic [2:0] op;
    logic [7:0] a, b;
    logic_unit_if #(.WIDTH(4)) lu4();
    logic_unit_if #(.WIDTH(8)) lu8();
    assign lu4.in_valid = in_valid;
    assign lu4.a = a[3:0];
    assign lu4.b = b[3:0];
    assign lu4.op = op;
    assign lu4.enable = enable;
    assign lu4.acc = acc;
    assign lu4.acc_clr = acc_clr;
    assign lu4.out_ready = out_ready;
    assign lu8.in_valid = in_valid;
    assign lu8.a = a;
    assign lu8.b = b;
    assign lu8.op = op;
    assign lu8.enable = enable;
    assign lu8.acc = acc;
    assign lu8.acc_clr = acc_clr;
    assign lu8.out_ready = out_ready;
    logic_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(lu4.slave));
    logic_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(lu8.slave));
    int chk = 0;
    int err = 0;
    logic [7:0] sb[$];
    logic [7:0] model_acc = 8'h00;
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic en;
        logic ac;
        logic cl;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[10];
    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
        end
    endtask
    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return y;
        endcase
    endfunction
    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic en, input logic ac, input logic cl,
                        input logic [7:0] e, output int w);
        op = o; a = x; b = y; enable = en; acc = ac; acc_clr = cl; in_valid = 1'b1; w = 0;
        forever begin
            @(negedge clk);
            if (lu8.in_ready) begin
                @(posedge clk);
                sb.push_back(e);
                model_acc = e;
                #1;
                break;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            w++;
            if (w > 50) begin
                chk++;
                err++;
                $display("FAIL accept_timeout in_ready stuck at %b want 1", lu8.in_ready);
                break;
            end
        end
        in_valid = 1'b0;
    endtask
    task automatic check_idle_state(input string n);
        check({n, "_valid8"}, {7'b0, lu8.out_valid}, 8'h00);
        check({n, "_ready8"}, {7'b0, lu8.in_ready}, 8'h01);
        check({n, "_res8"}, lu8.result, 8'h00);
        check({n, "_flags8"}, {5'b0, lu8.flag_zero, lu8.flag_ones, lu8.flag_parity}, 8'h00);
        check({n, "_acc8"}, dut8.acc_q, 8'h00);
        check({n, "_valid4"}, {7'b0, lu4.out_valid}, 8'h00);
        check({n, "_res4"}, {4'b0, lu4.result}, 8'h00);
        check({n, "_acc4"}, {4'b0, dut4.acc_q}, 8'h00);
    endtask
    task automatic drain_check(input string n);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check(n, 8'(sb.size()), 8'h00);
    endtask
    always @(negedge clk) begin
        if (rst_n && lu8.out_valid && lu8.out_ready) begin
            if (sb.size() == 0) begin
                chk++;
                err++;
                $display("FAIL unexpected_output got %h want none", lu8.result);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("res8", lu8.result, e);
                check("flags8", {5'b0, lu8.flag_zero, lu8.flag_ones, lu8.flag_parity},
                      {5'b0, e == 8'h00, e == 8'hFF, ^e});
                check("res4", {4'b0, lu4.result}, {4'b0, e[3:0]});
                check("flags4", {5'b0, lu4.flag_zero, lu4.flag_ones, lu4.flag_parity},
                      {5'b0, e[3:0] == 4'h0, e[3:0] == 4'hF, ^e[3:0]});
            end
        end
    end
    initial begin
        int w;
        logic [2:0] o;
        logic [7:0] x, y, ea, eb, e;
        logic en, ac, cl;
        tbl[0] = '{3'd0, 8'h0C, 8'h0A, 1'b1, 1'b0, 1'b0, 8'h08};
        tbl[1] = '{3'd3, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF};
        tbl[2] = '{3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{3'd1, 8'hFF, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03};
        tbl[4] = '{3'd2, 8'hFF, 8'h05, 1'b1, 1'b1, 1'b0, 8'h06};
        tbl[5] = '{3'd0, 8'hFF, 8'h04, 1'b1, 1'b1, 1'b0, 8'h04};
        tbl[6] = '{3'd6, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5};
        tbl[7] = '{3'd7, 8'hFF, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C};
        tbl[8] = '{3'd4, 8'h0F, 8'h30, 1'b1, 1'b0, 1'b0, 8'hC0};
        tbl[9] = '{3'd5, 8'hF0, 8'hCC, 1'b1, 1'b0, 1'b0, 8'hC3};
        rst_n = 1'b0;
        in_valid = 1'b0; enable = 1'b0; acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = 8'h00; b = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_state("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].en, tbl[i].ac, tbl[i].cl, tbl[i].exp, w);
            if (i == 0) begin
                check("latency_valid", {7'b0, lu8.out_valid}, 8'h01);
                check("latency_res", lu8.result, 8'h08);
            end
            if (i == 4 || i == 5) check("no_bubble", 8'(w), 8'h00);
        end
        drain_check("table_drain");
        out_ready = 1'b0;
        send(3'd1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b0, 8'h33, w);
        send(3'd0, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h30, w);
        check("full_ready", {7'b0, lu8.in_ready}, 8'h00);
        repeat (3) begin
            @(negedge clk);
            check("stall_res", lu8.result, 8'h33);
            check("stall_state", {6'b0, lu8.out_valid, lu8.in_ready}, 8'h02);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'd2, 8'h0F, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hF0, w);
        check("third_wait", 8'(w), 8'h01);
        drain_check("bp_drain");
        for (int i = 0; i < 1000; i++) begin
            o = 3'($urandom_range(0, 7));
            x = 8'($urandom);
            y = 8'($urandom);
            en = $urandom_range(0, 9) != 0;
            ac = 1'($urandom_range(0, 1));
            cl = $urandom_range(0, 9) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            ea = cl ? 8'h00 : (ac ? model_acc : x);
            eb = y;
            if (!en) begin
                ea = 8'h00;
                eb = 8'h00;
            end
            e = model(o, ea, eb);
            send(o, x, y, en, ac, cl, e, w);
        end
        drain_check("rand_drain");
        out_ready = 1'b0;
        send(3'd1, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 8'h03, w);
        send(3'd1, 8'h04, 8'h08, 1'b1, 1'b0, 1'b0, 8'h0C, w);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_state("midreset");
        sb.delete();
        model_acc = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'd1, 8'hAA, 8'h01, 1'b1, 1'b1, 1'b0, 8'h01, w);
        check("post_reset_res", lu8.result, 8'h01);
        drain_check("final_drain");
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
